// File: rtl/sysid_verifier.sv
// sysid_verifier: reads the ID word (address 0) and the timestamp word
// (address 1) from an Avalon-MM sysid slave on request, compares them against
// the build-time expected values and reports the outcome. Each read tolerates
// up to TIMEOUT_CYCLES consecutive stall cycles before the sequence aborts.
module sysid_verifier #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1473773398,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_stall_cnt;
    logic        r_avm_address;
    logic        r_avm_read;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_id_match;
    logic        w_ts_match;
    logic        w_stall_expired;

    // Full-width equality against the expected words, plus the abort condition:
    // the counter already holds TIMEOUT_CYCLES stalls and this cycle stalls too.
    assign w_id_match      = (avm_readdata == EXPECTED_ID);
    assign w_ts_match      = (avm_readdata == EXPECTED_TS);
    assign w_stall_expired = avm_waitrequest && (r_stall_cnt == LP_TIMEOUT);

    // Sequencer: all outputs are registered so the bus strobes stay glitch-free
    // and hold steady while the slave stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_stall_cnt   <= 16'd0;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_RD_ID;
                        r_stall_cnt   <= 16'd0;
                        r_avm_address <= 1'b0;
                        r_avm_read    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_id_value    <= 32'd0;
                        r_ts_value    <= 32'd0;
                    end
                end

                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        r_id_value    <= avm_readdata;
                        r_id_ok       <= w_id_match;
                        r_stall_cnt   <= 16'd0;
                        r_avm_address <= 1'b1;
                        r_state       <= ST_RD_TS;
                    end else if (w_stall_expired) begin
                        r_timeout     <= 1'b1;
                        r_avm_read    <= 1'b0;
                        r_avm_address <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_stall_cnt   <= r_stall_cnt + 16'd1;
                    end
                end

                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        r_ts_value    <= avm_readdata;
                        r_ts_ok       <= w_ts_match;
                        r_stall_cnt   <= 16'd0;
                        r_avm_read    <= 1'b0;
                        r_avm_address <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        // Timeout cannot be set on this path, so pass only needs both matches.
                        r_pass        <= r_id_ok & w_ts_match;
                        r_state       <= ST_DONE;
                    end else if (w_stall_expired) begin
                        r_timeout     <= 1'b1;
                        r_avm_read    <= 1'b0;
                        r_avm_address <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_stall_cnt   <= r_stall_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address = r_avm_address;
    assign avm_read    = r_avm_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_verifier.sv
// Bench for sysid_verifier: a stalling sysid slave model plus a transaction
// level reference that predicts the outcome of each check sequence.
module tb_sysid_verifier;

    localparam int          T   = 4;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1473773398;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int checks = 0;
    int errors = 0;

    // slave model state
    logic [31:0] sl_mem [2];
    int          sl_stall [2];
    int          sl_cnt = 0;

    sysid_verifier #(
        .EXPECTED_ID(EID),
        .EXPECTED_TS(ETS),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .done(done),
        .pass(pass),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    // Slave stalls each read for sl_stall[addr] cycles, then returns its word.
    assign avm_waitrequest = avm_read && (sl_cnt < sl_stall[avm_address]);
    assign avm_readdata    = sl_mem[avm_address];

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) sl_cnt <= sl_cnt + 1;
        else                             sl_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {26'd0, avm_read, avm_address, busy, done, pass, timeout}, 32'd0);
        check_eq({tag, "_oks"}, {30'd0, id_ok, ts_ok}, 32'd0);
        check_eq({tag, "_idv"}, id_value, 32'd0);
        check_eq({tag, "_tsv"}, ts_value, 32'd0);
    endtask

    // Run one check sequence and compare against the predicted outcome.
    task automatic run_txn(input int s0, input int s1, input logic [31:0] d0,
                           input logic [31:0] d1, input bit dbl);
        bit          to0, to1, e_to, e_idok, e_tsok, e_pass;
        logic [31:0] e_id, e_ts;
        int          e_rd0, e_rd1, e_lat;
        int          rdc [2];
        int          n;
        bit          prev_stall;
        logic        prev_addr;
        int          glitch;

        // reference outcome from the sequence rules
        to0    = (s0 > T);
        to1    = !to0 && (s1 > T);
        e_to   = to0 || to1;
        e_id   = to0 ? 32'd0 : d0;
        e_ts   = e_to ? 32'd0 : d1;
        e_idok = !to0 && (d0 == EID);
        e_tsok = !e_to && (d1 == ETS);
        e_pass = e_idok && e_tsok && !e_to;
        e_rd0  = to0 ? T + 1 : s0 + 1;
        e_rd1  = to0 ? 0 : (to1 ? T + 1 : s1 + 1);
        e_lat  = 1 + e_rd0 + e_rd1;

        sl_mem[0]   = d0;
        sl_mem[1]   = d1;
        sl_stall[0] = s0;
        sl_stall[1] = s1;
        rdc[0] = 0;
        rdc[1] = 0;
        glitch = 0;
        prev_stall = 1'b0;
        prev_addr  = 1'b0;
        n = 0;

        @(negedge clock);
        start = 1'b1;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                start = dbl;
                check_eq("busy_after_start", {31'd0, busy}, 32'd1);
                check_eq("cleared_on_start", {29'd0, done, timeout, pass}, 32'd0);
                check_eq("idv_cleared", id_value, 32'd0);
            end else begin
                start = 1'b0;
            end
            if (avm_read) begin
                rdc[avm_address]++;
                if (prev_stall && avm_address != prev_addr) glitch++;
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (done) break;
        end
        start = 1'b0;
        check_eq("done_bound", {31'd0, done}, 32'd1);
        check_eq("latency", n, e_lat);
        check_eq("rd_cycles_addr0", rdc[0], e_rd0);
        check_eq("rd_cycles_addr1", rdc[1], e_rd1);
        check_eq("addr_stable", glitch, 0);
        check_eq("flags", {27'd0, busy, avm_read, pass, id_ok, ts_ok},
                 {27'd0, 1'b0, 1'b0, e_pass, e_idok, e_tsok});
        check_eq("timeout", {31'd0, timeout}, {31'd0, e_to});
        check_eq("id_value", id_value, e_id);
        check_eq("ts_value", ts_value, e_ts);
        // done must hold while idle in DONE
        repeat (2) @(negedge clock);
        check_eq("done_held", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        sl_mem[0] = 32'd0;
        sl_mem[1] = ETS;
        sl_stall[0] = 0;
        sl_stall[1] = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("no_read_idle", {31'd0, avm_read}, 32'd0);

        // nominal sysid contents
        run_txn(0, 0, 32'd0, ETS, 1'b0);
        // wrong timestamp
        run_txn(0, 0, 32'd0, 32'h12345678, 1'b0);
        // slave never answers the ID read
        run_txn(1000, 0, 32'd0, ETS, 1'b0);
        // exactly the tolerated number of stalls on both reads
        run_txn(T, T, 32'd0, ETS, 1'b0);
        // one stall too many on the timestamp read
        run_txn(0, T + 1, 32'd0, ETS, 1'b0);
        // start repeated while busy, then restart from DONE
        run_txn(1, 2, 32'd0, ETS, 1'b1);
        run_txn(0, 0, 32'hDEADBEEF, ETS, 1'b0);

        // reset asserted mid timestamp read
        sl_mem[0] = 32'd0;
        sl_mem[1] = ETS;
        sl_stall[0] = 0;
        sl_stall[1] = 3;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(avm_read && avm_address) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("reached_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("no_read_after_reset", {30'd0, avm_read, busy}, 32'd0);
        run_txn(0, 0, 32'd0, ETS, 1'b0);

        // randomized sequences
        for (int i = 0; i < 30; i++) begin
            int          s0, s1;
            logic [31:0] d0, d1;
            s0 = $urandom_range(0, T + 2);
            s1 = $urandom_range(0, T + 2);
            d0 = ($urandom_range(0, 2) == 0) ? $urandom : EID;
            d1 = ($urandom_range(0, 2) == 0) ? $urandom : ETS;
            run_txn(s0, s1, d0, d1, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
